// File: rtl/rtf65002_muldiv.sv
// Iterative 32-bit multiply/divide unit: shift-add MUL, restoring DIV/MOD, sign fix-up pass.
// Define RTF65002_DIVMOD_EN to build the divider; otherwise ops 2-5 complete as reserved ops.
module rtf65002_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] prod,
  output logic [31:0] res,
  output logic        dvz
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;    // MUL: {partial product, multiplier}; DIV: quotient in [31:0]
  logic [31:0] opnd;   // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic        neg_q;

  logic        is_signed, is_mul, is_divmod;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_fix;

  // Odd opcodes are the signed variants; op 7 is reserved and its flags are never used.
  assign is_signed = op[0];
  assign is_mul    = (op[2:1] == 2'b00);
  assign is_divmod = op[2] ^ op[1];
  assign a_mag     = (is_signed && a[31]) ? -a : a;
  assign b_mag     = (is_signed && b[31]) ? -b : b;

  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
  assign mul_fix = neg_q ? -acc : acc;

`ifdef RTF65002_DIVMOD_EN
  logic [1:0]  op_r;
  logic        neg_r;
  logic [31:0] rem;
  logic [32:0] rem_sh, rem_diff;
  logic        rem_ge;
  logic [31:0] quo_fix, rem_fix;

  // Bit 32 of the 33-bit trial difference is the borrow: clear means the divisor fits.
  assign rem_sh   = {rem, acc[31]};
  assign rem_diff = rem_sh - {1'b0, opnd};
  assign rem_ge   = ~rem_diff[32];
  assign quo_fix  = neg_q ? -acc[31:0] : acc[31:0];
  assign rem_fix  = neg_r ? -rem : rem;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_mul) state_nxt = MUL;
`ifdef RTF65002_DIVMOD_EN
          else if (is_divmod && (b != 32'd0)) state_nxt = DIV;
`endif
          else state_nxt = DONE;
        end
      end
      MUL, DIV: if (cnt == 5'd31) state_nxt = FIX;
      FIX:      state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
      prod  <= '0;
      res   <= '0;
      dvz   <= 1'b0;
`ifdef RTF65002_DIVMOD_EN
      op_r  <= '0;
      neg_r <= 1'b0;
      rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            prod  <= '0;
            dvz   <= 1'b0;
            neg_q <= is_signed & (a[31] ^ b[31]);
            if (is_mul) begin
              opnd <= a_mag;
              acc  <= {32'd0, b_mag};
            end else begin
              opnd <= b_mag;
              acc  <= {32'd0, a_mag};
            end
`ifdef RTF65002_DIVMOD_EN
            op_r  <= op[2:1];
            neg_r <= is_signed & a[31];
            rem   <= '0;
            if (is_divmod && (b == 32'd0)) begin
              dvz  <= 1'b1;
              prod <= {a, 32'hFFFF_FFFF};
              res  <= op[2] ? a : 32'hFFFF_FFFF;
            end else if (!is_mul && !is_divmod) begin
              res <= '0;
            end
`else
            if (!is_mul) res <= '0;
`endif
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
        end
`ifdef RTF65002_DIVMOD_EN
        DIV: begin
          rem <= rem_ge ? rem_diff[31:0] : rem_sh[31:0];
          acc <= {acc[63:32], acc[30:0], rem_ge};
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          if (op_r == 2'b00) begin
            prod <= mul_fix;
            res  <= mul_fix[31:0];
          end else begin
            prod <= {rem_fix, quo_fix};
            res  <= op_r[1] ? rem_fix : quo_fix;
          end
        end
`else
        FIX: begin
          prod <= mul_fix;
          res  <= mul_fix[31:0];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
